if_stage: RTL and testbench

- Instruction-fetch pipeline stage, directly upstream of the decode stage.
- Holds the fetch PC and issues one instruction-SRAM request at a time over a req/addr_ok/data_ok handshake.
- Buffers the returned instruction until decode accepts it, using the valid/allowin handshake.
- Raises fetch address exceptions and cancels in-flight fetches when writeback flushes the pipe.

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/if_inst_buf.sv | 72 +++++++
 rtl/if_stage.sv | 126 ++++++++++++
 tb/tb_if_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants, state encoding and helpers for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] IF_RESET_PC   = 32'hBFC0_0000;
  localparam logic [4:0]  EXC_ADEL      = 5'h04;
  localparam logic [4:0]  EXC_NONE      = 5'h00;
  localparam logic [31:0] INST_INIT     = 32'h0000_0000;
  localparam logic [31:0] VADDR_INIT    = 32'h0000_0000;
  localparam logic        EXC_FLAG_INIT = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_CANCEL = 3'd4
  } if_state_e;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_inst_buf.sv
// Holding register set for the fetched instruction and its sideband fields.
module if_inst_buf
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] ld_inst,
  input  logic        ld_exc,
  input  logic [4:0]  ld_exc_code,
  input  logic [31:0] ld_vaddr,
  input  logic [31:0] ld_pc,
  output logic [31:0] inst_out,
  output logic        exc_out,
  output logic [4:0]  exc_code_out,
  output logic [31:0] vaddr_out,
  output logic [31:0] pc_out
);

  logic [31:0] inst_q, inst_d;
  logic        exc_q, exc_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] vaddr_q, vaddr_d;
  logic [31:0] pc_q, pc_d;

  // A flush wipes the payload but leaves the PC; load only happens outside a flush.
  always_comb begin
    inst_d     = inst_q;
    exc_d      = exc_q;
    exc_code_d = exc_code_q;
    vaddr_d    = vaddr_q;
    pc_d       = pc_q;
    if (clr) begin
      inst_d     = INST_INIT;
      exc_d      = EXC_FLAG_INIT;
      exc_code_d = EXC_NONE;
      vaddr_d    = VADDR_INIT;
    end else if (load) begin
      inst_d     = ld_inst;
      exc_d      = ld_exc;
      exc_code_d = ld_exc_code;
      vaddr_d    = ld_vaddr;
      pc_d       = ld_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q     <= INST_INIT;
      exc_q      <= EXC_FLAG_INIT;
      exc_code_q <= EXC_NONE;
      vaddr_q    <= VADDR_INIT;
      pc_q       <= RESET_PC;
    end else begin
      inst_q     <= inst_d;
      exc_q      <= exc_d;
      exc_code_q <= exc_code_d;
      vaddr_q    <= vaddr_d;
      pc_q       <= pc_d;
    end
  end

  assign inst_out     = inst_q;
  assign exc_out      = exc_q;
  assign exc_code_out = exc_code_q;
  assign vaddr_out    = vaddr_q;
  assign pc_out       = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: single-outstanding SRAM fetch, hold buffer, flush/cancel.
// Optional stall counter output enabled by defining IF_STALL_CNT_EN.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin_in,
  output logic        if_valid_out,
  input  logic [31:0] id_nextPC_in,
  input  logic        wb_ClrStpJmp_in,
  output logic [31:0] if_NPC_fast_out,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NPC_out,
  output logic [31:0] if_NNPC_out,
  output logic [31:0] if_Instruct_out,
  output logic        if_exception_out,
  output logic [4:0]  if_ExcCode_out,
  output logic [31:0] if_error_VAddr_out,
  output logic        inst_req_out,
  output logic [31:0] inst_addr_out,
  input  logic        inst_addr_ok_in,
  input  logic        inst_data_ok_in,
  input  logic [31:0] inst_rdata_in
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0] if_stall_cnt_out
`endif
);

  if_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        misalign, flush, handoff;
  logic        buf_load, buf_clr;
  logic [31:0] buf_pc;

  assign misalign = pc_misaligned(fetch_pc_q);
  assign flush    = wb_ClrStpJmp_in;
  assign handoff  = (state_q == S_HOLD) && id_allowin_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Flush outranks everything; an accepted-but-unreturned request must drain through CANCEL.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (flush || handoff) fetch_pc_d = id_nextPC_in;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (flush)                       state_d = (inst_addr_ok_in && !misalign) ? S_CANCEL : S_REQ;
        else if (misalign)               state_d = S_HOLD;
        else if (inst_addr_ok_in)        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush)                       state_d = inst_data_ok_in ? S_REQ : S_CANCEL;
        else if (inst_data_ok_in)        state_d = S_HOLD;
      end
      S_HOLD:   if (flush || id_allowin_in) state_d = S_REQ;
      S_CANCEL: if (inst_data_ok_in)        state_d = S_REQ;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_valid_out  = (state_q == S_HOLD);
    inst_req_out  = (state_q == S_REQ) && !misalign;
    inst_addr_out = (state_q == S_REQ) ? fetch_pc_q : 32'h0;
    buf_clr       = flush;
    buf_load      = !flush && (((state_q == S_WAIT) && inst_data_ok_in) ||
                               ((state_q == S_REQ) && misalign));
  end

  if_inst_buf #(.RESET_PC(RESET_PC)) u_buf (
    .clk          (clk),
    .rst          (rst),
    .clr          (buf_clr),
    .load         (buf_load),
    .ld_inst      (misalign ? INST_INIT : inst_rdata_in),
    .ld_exc       (misalign),
    .ld_exc_code  (misalign ? EXC_ADEL : EXC_NONE),
    .ld_vaddr     (misalign ? fetch_pc_q : VADDR_INIT),
    .ld_pc        (fetch_pc_q),
    .inst_out     (if_Instruct_out),
    .exc_out      (if_exception_out),
    .exc_code_out (if_ExcCode_out),
    .vaddr_out    (if_error_VAddr_out),
    .pc_out       (buf_pc)
  );

  assign if_PC_out       = buf_pc;
  assign if_NPC_out      = buf_pc + 32'd4;
  assign if_NNPC_out     = buf_pc + 32'd8;
  assign if_NPC_fast_out = buf_pc + 32'd4;

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_inc;

  assign stall_inc = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_CANCEL) ||
                     ((state_q == S_HOLD) && !id_allowin_in);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 32'h0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign if_stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed fetch, stall, exception, flush and wrap scenarios.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_allowin_in;
  logic        if_valid_out;
  logic [31:0] id_nextPC_in;
  logic        wb_ClrStpJmp_in;
  logic [31:0] if_NPC_fast_out, if_PC_out, if_NPC_out, if_NNPC_out;
  logic [31:0] if_Instruct_out;
  logic        if_exception_out;
  logic [4:0]  if_ExcCode_out;
  logic [31:0] if_error_VAddr_out;
  logic        inst_req_out;
  logic [31:0] inst_addr_out;
  logic        inst_addr_ok_in, inst_data_ok_in;
  logic [31:0] inst_rdata_in;
`ifdef IF_STALL_CNT_EN
  logic [31:0] if_stall_cnt_out;
  logic [31:0] cnt0;
`endif

  if_stage dut (
    .clk                (clk),
    .rst                (rst),
    .id_allowin_in      (id_allowin_in),
    .if_valid_out       (if_valid_out),
    .id_nextPC_in       (id_nextPC_in),
    .wb_ClrStpJmp_in    (wb_ClrStpJmp_in),
    .if_NPC_fast_out    (if_NPC_fast_out),
    .if_PC_out          (if_PC_out),
    .if_NPC_out         (if_NPC_out),
    .if_NNPC_out        (if_NNPC_out),
    .if_Instruct_out    (if_Instruct_out),
    .if_exception_out   (if_exception_out),
    .if_ExcCode_out     (if_ExcCode_out),
    .if_error_VAddr_out (if_error_VAddr_out),
    .inst_req_out       (inst_req_out),
    .inst_addr_out      (inst_addr_out),
    .inst_addr_ok_in    (inst_addr_ok_in),
    .inst_data_ok_in    (inst_data_ok_in),
    .inst_rdata_in      (inst_rdata_in)
`ifdef IF_STALL_CNT_EN
    ,
    .if_stall_cnt_out   (if_stall_cnt_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] vaddr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!inst_req_out && n < 20) begin
      tick();
      n++;
    end
    if (!inst_req_out) begin
      checks++;
      errors++;
      $display("FAIL wait_req: got no request within 20 cycles");
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input int dly);
    exp_t e;
    wait_req();
    e.pc = pc; e.inst = data; e.exc = 1'b0; e.code = 5'h00; e.vaddr = 32'h0;
    addr_q.push_back(pc);
    exp_q.push_back(e);
    repeat (dly) tick();
    inst_addr_ok_in = 1'b1;
    tick();
    inst_addr_ok_in = 1'b0;
    inst_data_ok_in = 1'b1;
    inst_rdata_in   = data;
    tick();
    inst_data_ok_in = 1'b0;
    check("valid_after_data", if_valid_out, 1'b1);
  endtask

  task automatic handoff(input logic [31:0] npc);
    id_nextPC_in  = npc;
    id_allowin_in = 1'b1;
    tick();
    id_allowin_in = 1'b0;
  endtask

  // Monitor: request addresses and handed-off instructions against the queues.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] a;
    logic [31:0] p4, p8;
    if (!rst) begin
      if (inst_req_out && inst_addr_ok_in) begin
        if (addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr %0h expected none", inst_addr_out);
        end else begin
          a = addr_q.pop_front();
          check("req_addr", inst_addr_out, a);
        end
      end
      if (if_valid_out && exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_valid: got inst %0h expected no valid", if_Instruct_out);
      end else if (if_valid_out && id_allowin_in) begin
        e  = exp_q.pop_front();
        p4 = e.pc + 32'd4;
        p8 = e.pc + 32'd8;
        check("out_payload", {if_Instruct_out, if_exception_out, if_ExcCode_out, if_error_VAddr_out},
              {e.inst, e.exc, e.code, e.vaddr});
        check("out_pcs", {if_PC_out, if_NPC_out, if_NNPC_out, if_NPC_fast_out}, {e.pc, p4, p8, p4});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1; id_allowin_in = 1'b0; id_nextPC_in = 32'h0; wb_ClrStpJmp_in = 1'b0;
    inst_addr_ok_in = 1'b0; inst_data_ok_in = 1'b0; inst_rdata_in = 32'h0;
    tick(); tick();
    check("rst_ctrl", {if_valid_out, inst_req_out}, 2'b00);
    check("rst_pcs", {if_PC_out, if_NPC_out, if_NNPC_out}, {32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008});
    check("rst_data", {if_Instruct_out, if_exception_out, if_ExcCode_out, if_error_VAddr_out}, 70'h0);
`ifdef IF_STALL_CNT_EN
    check("rst_stall_cnt", if_stall_cnt_out, 32'h0);
`endif
    rst = 1'b0;
    tick();

    // Basic fetch, then stall in HOLD
    fetch(32'hBFC0_0000, 32'h2408_0001, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_stable", {if_valid_out, inst_req_out, if_Instruct_out, if_PC_out},
            {1'b1, 1'b0, 32'h2408_0001, 32'hBFC0_0000});
    end
    handoff(32'hBFC0_0100);

    fetch(32'hBFC0_0100, 32'h3C1D_0010, 0);
    e.pc = 32'hBFC0_0002; e.inst = 32'h0; e.exc = 1'b1; e.code = 5'h04; e.vaddr = 32'hBFC0_0002;
    exp_q.push_back(e);
    handoff(32'hBFC0_0002);

    // Misaligned fetch: no SRAM request, straight to HOLD with AdEL
    check("misalign_no_req", inst_req_out, 1'b0);
    tick();
    check("misalign_hold", {if_valid_out, if_exception_out, if_ExcCode_out}, {1'b1, 1'b1, 5'h04});
    handoff(32'hBFC0_0200);

    // Flush while waiting for data
    wait_req();
    addr_q.push_back(32'hBFC0_0200);
    inst_addr_ok_in = 1'b1;
    tick();
    inst_addr_ok_in = 1'b0;
    wb_ClrStpJmp_in = 1'b1; id_nextPC_in = 32'hBFC0_0380;
    tick();
    wb_ClrStpJmp_in = 1'b0;
    check("cancel_idle", {if_valid_out, inst_req_out}, 2'b00);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("cancel_no_valid", {if_valid_out, inst_req_out}, 2'b00);
    end
    inst_data_ok_in = 1'b1; inst_rdata_in = 32'hDEAD_BEEF;
    tick();
    inst_data_ok_in = 1'b0;
    check("cancel_drop", {if_valid_out, inst_req_out, inst_addr_out}, {1'b0, 1'b1, 32'hBFC0_0380});
    fetch(32'hBFC0_0380, 32'h8C02_0004, 0);
    handoff(32'hBFC0_0384);

    // Flush coinciding with data return
    wait_req();
    addr_q.push_back(32'hBFC0_0384);
    inst_addr_ok_in = 1'b1;
    tick();
    inst_addr_ok_in = 1'b0;
    inst_data_ok_in = 1'b1; inst_rdata_in = 32'hBAD0_BAD0;
    wb_ClrStpJmp_in = 1'b1; id_nextPC_in = 32'hBFC0_0400;
    tick();
    inst_data_ok_in = 1'b0; wb_ClrStpJmp_in = 1'b0;
    check("flush_data_drop", {if_valid_out, inst_req_out, inst_addr_out}, {1'b0, 1'b1, 32'hBFC0_0400});
    fetch(32'hBFC0_0400, 32'h1111_2222, 0);
    handoff(32'hFFFF_FFFC);

    // PC wrap
    fetch(32'hFFFF_FFFC, 32'h0000_000C, 0);
    check("npc_wrap", if_NPC_out, 32'h0);
    handoff(32'hBFC0_0600);

    // Flush in REQ before addr_ok redirects the request
    wait_req();
    check("req_addr_pre", inst_addr_out, 32'hBFC0_0600);
    wb_ClrStpJmp_in = 1'b1; id_nextPC_in = 32'hBFC0_0500;
    tick();
    wb_ClrStpJmp_in = 1'b0;
    check("req_redirect", {inst_req_out, inst_addr_out}, {1'b1, 32'hBFC0_0500});
`ifdef IF_STALL_CNT_EN
    cnt0 = if_stall_cnt_out;
`endif
    fetch(32'hBFC0_0500, 32'h2402_000A, 4);
`ifdef IF_STALL_CNT_EN
    check("stall_cnt_delta", (if_stall_cnt_out - cnt0) >= 32'd4, 1'b1);
`endif
    handoff(32'hBFC0_0504);
    tick(); tick(); tick();
    check("queues_drained", {exp_q.size() == 0, addr_q.size() == 0}, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
